// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_ZERO = 8'h00;
    localparam bcd2_t BCD_MAX  = 8'h59;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear and a carry out on the 59 -> 00 step.
// nxt is the value q takes at the next edge, so a parent can register derived outputs in step.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  clr,
    output bcd2_t q,
    output bcd2_t nxt,
    output logic  carry
);

    always_comb begin
        nxt   = q;
        carry = 1'b0;
        if (clr) begin
            nxt = BCD_ZERO;
        end else if (inc) begin
            if (q == BCD_MAX) begin
                nxt   = BCD_ZERO;
                carry = 1'b1;
            end else if (q[3:0] == 4'd9) begin
                nxt = {q[7:4] + 4'd1, 4'd0};
            end else begin
                nxt = {q[7:4], q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Single-channel mm:ss stopwatch: run/pause FSM, prescaler, BCD live count, lap freeze.
// Handshake: start_stop, clear and lap are single-cycle pulses sampled on every rising edge; no ready.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter bit ROLLOVER = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start_stop,
    input  logic  clear,
    input  logic  lap,
    output bcd2_t secs,
    output bcd2_t mins,
    output logic  running,
    output logic  lap_active,
    output logic  tick,
    output logic  ovf
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          lap_q, lap_d;
    bcd2_t         lap_secs_q, lap_secs_d, lap_mins_q, lap_mins_d;
    bcd2_t         live_secs, live_secs_nxt, live_mins, live_mins_nxt;
    logic          sec_carry, min_carry;
    logic          do_tick, at_max, hold, secs_inc, ovf_d;

    // A second elapses when the prescaler wraps in RUN; clear wins over it.
    assign do_tick  = (state_q == RUN) && (presc_q == PRESC_MAX) && !clear;
    assign at_max   = (live_secs == BCD_MAX) && (live_mins == BCD_MAX);
    assign hold     = at_max && !ROLLOVER;
    assign secs_inc = do_tick && !hold;
    assign ovf_d    = min_carry || (do_tick && hold);

    bcd_mod60 u_secs (
        .clk   (clk),
        .rst   (rst),
        .inc   (secs_inc),
        .clr   (clear),
        .q     (live_secs),
        .nxt   (live_secs_nxt),
        .carry (sec_carry)
    );

    bcd_mod60 u_mins (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_carry),
        .clr   (clear),
        .q     (live_mins),
        .nxt   (live_mins_nxt),
        .carry (min_carry)
    );

    // clear is applied first, then start_stop toggles whatever state clear left behind.
    always_comb begin
        state_d = state_q;
        if (clear && state_q != RUN) begin
            state_d = IDLE;
        end
        if (start_stop) begin
            state_d = (state_d == RUN) ? PAUSE : RUN;
        end else if (do_tick && hold) begin
            state_d = PAUSE;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = do_tick ? '0 : presc_q + PW'(1);
        end
    end

    // Lap captures the registered live value, i.e. the pre-increment count on a tick cycle.
    always_comb begin
        lap_d      = lap_q;
        lap_secs_d = lap_secs_q;
        lap_mins_d = lap_mins_q;
        if (clear) begin
            lap_d = 1'b0;
        end else if (lap) begin
            if (!lap_q) begin
                lap_d      = 1'b1;
                lap_secs_d = live_secs;
                lap_mins_d = live_mins;
            end else begin
                lap_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            lap_q      <= 1'b0;
            lap_secs_q <= BCD_ZERO;
            lap_mins_q <= BCD_ZERO;
            secs       <= BCD_ZERO;
            mins       <= BCD_ZERO;
            running    <= 1'b0;
            lap_active <= 1'b0;
            tick       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            lap_q      <= lap_d;
            lap_secs_q <= lap_secs_d;
            lap_mins_q <= lap_mins_d;
            secs       <= lap_d ? lap_secs_d : live_secs_nxt;
            mins       <= lap_d ? lap_mins_d : live_mins_nxt;
            running    <= (state_d == RUN);
            lap_active <= lap_d;
            tick       <= do_tick;
            ovf        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: a wrapping and a saturating instance share stimulus and are
// compared every cycle against a seconds-count model, plus directed literal checks.
module tb_bcd_stopwatch;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [7:0] secs_w[2];
    logic [7:0] mins_w[2];
    logic       running_w[2];
    logic       lap_w[2];
    logic       tick_w[2];
    logic       ovf_w[2];

    int errors = 0;
    int checks = 0;

    // Model: index 0 wraps at 59:59, index 1 saturates.
    int m_total[2] = '{0, 0};
    int m_pre[2]   = '{0, 0};
    int m_lapv[2]  = '{0, 0};
    bit m_run[2]   = '{0, 0};
    bit m_lapon[2] = '{0, 0};
    bit m_tick[2]  = '{0, 0};
    bit m_ovf[2]   = '{0, 0};

    always #5 clk = ~clk;

    bcd_stopwatch #(.TICK_DIV(DIV), .ROLLOVER(1'b1)) dut_r (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .secs(secs_w[0]), .mins(mins_w[0]), .running(running_w[0]),
        .lap_active(lap_w[0]), .tick(tick_w[0]), .ovf(ovf_w[0])
    );

    bcd_stopwatch #(.TICK_DIV(DIV), .ROLLOVER(1'b0)) dut_s (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .secs(secs_w[1]), .mins(mins_w[1]), .running(running_w[1]),
        .lap_active(lap_w[1]), .tick(tick_w[1]), .ovf(ovf_w[1])
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Model update: elapsed seconds as a plain integer 0..3599.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_total[k] = 0; m_pre[k] = 0; m_lapv[k] = 0;
                m_run[k] = 0; m_lapon[k] = 0; m_tick[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit stop;
                stop = 0;
                m_tick[k] = 0;
                m_ovf[k] = 0;
                if (clear) m_lapon[k] = 0;
                else if (lap) begin
                    if (!m_lapon[k]) begin
                        m_lapv[k] = m_total[k];
                        m_lapon[k] = 1;
                    end else m_lapon[k] = 0;
                end
                if (clear) begin
                    m_total[k] = 0;
                    m_pre[k] = 0;
                end else if (m_run[k]) begin
                    if (m_pre[k] == DIV - 1) begin
                        m_pre[k] = 0;
                        m_tick[k] = 1;
                        if (m_total[k] == 3599) begin
                            m_ovf[k] = 1;
                            if (k == 0) m_total[k] = 0;
                            else stop = 1;
                        end else m_total[k] = m_total[k] + 1;
                    end else m_pre[k] = m_pre[k] + 1;
                end
                if (start_stop) m_run[k] = !m_run[k];
                else if (stop) m_run[k] = 0;
            end
        end
    end

    // Scoreboard compare on every falling edge outside reset.
    always @(negedge clk) begin
        int shown;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                shown = m_lapon[k] ? m_lapv[k] : m_total[k];
                chk("secs", k, secs_w[k], to_bcd(shown % 60));
                chk("mins", k, mins_w[k], to_bcd(shown / 60));
                chk("running", k, {7'd0, running_w[k]}, {7'd0, m_run[k]});
                chk("lap_active", k, {7'd0, lap_w[k]}, {7'd0, m_lapon[k]});
                chk("tick", k, {7'd0, tick_w[k]}, {7'd0, m_tick[k]});
                chk("ovf", k, {7'd0, ovf_w[k]}, {7'd0, m_ovf[k]});
            end
        end
    end

    task automatic pulse(input bit ss, input bit cl, input bit lp);
        @(negedge clk);
        start_stop = ss;
        clear = cl;
        lap = lp;
        @(negedge clk);
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
    endtask

    task automatic wait_tick(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_w[k] !== 1'b1 && n < 4 * DIV);
        checks++;
        if (tick_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout[%0d] at %0t: got no tick in %0d cycles, expected one", k, $time, n);
        end
    endtask

    task automatic chk_all_zero();
        for (int k = 0; k < 2; k++) begin
            chk("rst_secs", k, secs_w[k], 8'h00);
            chk("rst_mins", k, mins_w[k], 8'h00);
            chk("rst_running", k, {7'd0, running_w[k]}, 8'h00);
            chk("rst_lap", k, {7'd0, lap_w[k]}, 8'h00);
            chk("rst_tick", k, {7'd0, tick_w[k]}, 8'h00);
            chk("rst_ovf", k, {7'd0, ovf_w[k]}, 8'h00);
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk_all_zero();
        rst = 1'b0;

        // First tick DIV cycles after start, tenth second reads 8'h10
        pulse(1, 0, 0);
        repeat (DIV) @(negedge clk);
        chk("first_tick", 0, {7'd0, tick_w[0]}, 8'h01);
        chk("first_secs", 0, secs_w[0], 8'h01);
        repeat (9) wait_tick(0);
        chk("tenth_secs", 0, secs_w[0], 8'h10);

        // Pause after two prescaler steps, resume: tick two cycles later
        wait_tick(0);
        pulse(1, 0, 0);
        repeat (20) @(negedge clk);
        pulse(1, 0, 0);
        @(negedge clk);
        chk("resume_no_tick", 0, {7'd0, tick_w[0]}, 8'h00);
        @(negedge clk);
        chk("resume_tick", 0, {7'd0, tick_w[0]}, 8'h01);

        // Lap at 00:05 holds through three ticks, release shows 00:08
        pulse(0, 1, 0);
        repeat (5) wait_tick(0);
        chk("lap_pre", 0, secs_w[0], 8'h05);
        pulse(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(0);
            chk("lap_hold", 0, secs_w[0], 8'h05);
            chk("lap_flag", 0, {7'd0, lap_w[0]}, 8'h01);
        end
        pulse(0, 0, 1);
        chk("lap_release", 0, secs_w[0], 8'h08);

        // clear+start_stop in RUN at 00:07 with lap held
        pulse(0, 1, 0);
        repeat (7) wait_tick(0);
        chk("pre_clear", 0, secs_w[0], 8'h07);
        pulse(0, 0, 1);
        pulse(1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            chk("clr_ss_secs", k, secs_w[k], 8'h00);
            chk("clr_ss_running", k, {7'd0, running_w[k]}, 8'h00);
            chk("clr_ss_lap", k, {7'd0, lap_w[k]}, 8'h00);
        end

        // Count to 59:59 then one more second: wrap vs saturate
        pulse(1, 0, 0);
        repeat (3599) wait_tick(0);
        for (int k = 0; k < 2; k++) begin
            chk("max_secs", k, secs_w[k], 8'h59);
            chk("max_mins", k, mins_w[k], 8'h59);
        end
        wait_tick(0);
        chk("wrap_secs", 0, secs_w[0], 8'h00);
        chk("wrap_mins", 0, mins_w[0], 8'h00);
        chk("wrap_ovf", 0, {7'd0, ovf_w[0]}, 8'h01);
        chk("wrap_running", 0, {7'd0, running_w[0]}, 8'h01);
        chk("sat_secs", 1, secs_w[1], 8'h59);
        chk("sat_mins", 1, mins_w[1], 8'h59);
        chk("sat_ovf", 1, {7'd0, ovf_w[1]}, 8'h01);
        chk("sat_running", 1, {7'd0, running_w[1]}, 8'h00);
        pulse(1, 0, 0);
        wait_tick(1);
        chk("resat_secs", 1, secs_w[1], 8'h59);
        chk("resat_ovf", 1, {7'd0, ovf_w[1]}, 8'h01);
        chk("resat_running", 1, {7'd0, running_w[1]}, 8'h00);

        // Random pulses, checked by the scoreboard
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start_stop = ($urandom_range(0, 19) == 0);
            clear = ($urandom_range(0, 59) == 0);
            lap = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;

        // Asynchronous reset mid-prescale
        pulse(0, 1, 0);
        if (!m_run[0]) pulse(1, 0, 0);
        repeat (DIV + 2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero();
        @(negedge clk);
        rst = 1'b0;
        pulse(1, 0, 0);
        repeat (DIV) @(negedge clk);
        chk("post_rst_tick", 0, {7'd0, tick_w[0]}, 8'h01);
        chk("post_rst_secs", 0, secs_w[0], 8'h01);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
